// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler: init sweep after reset or clear, then
// round-robin arbitration of ALU, load and link write-backs onto one port.
module regfile_write_sched #(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE  = '0,
    parameter int                R0_WRITABLE = 0,
    parameter int                CNT_W       = 8
) (
    input  logic              CLOCK_50,
    input  logic              resetIn,
    input  logic [2:0]        req_valid,
    input  logic [4:0]        req_addr0,
    input  logic [4:0]        req_addr1,
    input  logic [4:0]        req_addr2,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    output logic [2:0]        req_ready,
    input  logic              clear_req,
    output logic              wr_en,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              init_done,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic              state;
    logic [4:0]        cnt;
    logic [1:0]        last;
    logic [1:0]        gidx;
    logic [1:0]        cand;
    logic              found;
    logic              multi;
    logic              sel_wr_en;
    logic [4:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Scan requesters in rotation starting just after the last grant.
    always_comb begin
        req_ready = '0;
        gidx      = '0;
        cand      = '0;
        found     = 1'b0;
        if (state == ST_RUN && !clear_req) begin
            for (int unsigned k = 1; k <= 3; k++) begin
                cand = 2'((32'(last) + k) % 3);
                if (!found && req_valid[cand]) begin
                    found           = 1'b1;
                    gidx            = cand;
                    req_ready[cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (gidx)
            2'd1:    begin sel_addr = req_addr1; sel_data = req_data1; end
            2'd2:    begin sel_addr = req_addr2; sel_data = req_data2; end
            default: begin sel_addr = req_addr0; sel_data = req_data0; end
        endcase
        sel_wr_en = (sel_addr != 5'd0) || (R0_WRITABLE != 0);
        multi     = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2])
                  | (req_valid[1] & req_valid[2]);
    end

    always_ff @(posedge CLOCK_50 or posedge resetIn) begin
        if (resetIn) begin
            state        <= ST_INIT;
            cnt          <= '0;
            last         <= 2'd2;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            init_done    <= 1'b0;
            conflict_cnt <= '0;
        end else if (state == ST_INIT) begin
            wr_en   <= 1'b1;
            wr_addr <= cnt;
            wr_data <= INIT_VALUE;
            if (cnt == 5'd31) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end else begin
            if (multi && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            if (clear_req) begin
                state     <= ST_INIT;
                cnt       <= '0;
                init_done <= 1'b0;
                wr_en     <= 1'b0;
            end else if (found) begin
                wr_en   <= sel_wr_en;
                wr_addr <= sel_addr;
                wr_data <= sel_data;
                last    <= gidx;
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

endmodule
